// File: rtl/conv_sequencer.sv
// Frame sequencer for the convolver: loads kernel weights, then streams pixel columns.
// It drives the controlpath mode and the valid/ready handshakes, and it keeps the window position counters.
module conv_sequencer #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             reload_req,
  input  logic             weight_valid,
  output logic             weight_ready,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic [1:0]       state,
  output logic [3:0]       weight_addr,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             window_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_LOAD_W     = 2'b01,
    S_SHIFT      = 2'b10,
    S_SHIFT_LOAD = 2'b11
  } state_t;

  localparam logic [3:0]       LAST_W   = 4'(KERNEL_SIZE * KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - KERNEL_SIZE);
  localparam logic [CNT_W-1:0] WIN_COL  = CNT_W'(KERNEL_SIZE - 1);

  state_t           state_q, state_d;
  logic [3:0]       weight_addr_q, weight_addr_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic             window_valid_q, window_valid_d;
  logic             done_q, done_d;
  logic             frame_end_pending_q, frame_end_pending_d;

  logic w_acc, p_acc, last_w, col_last, frame_end;

  // The mode bits double as the ready strobes: bit 0 means weight write and bit 1 means shift.
  assign weight_ready = state_q[0];
  assign pixel_ready  = state_q[1];
  assign w_acc        = weight_valid & state_q[0];
  assign p_acc        = pixel_valid & state_q[1];
  assign last_w       = w_acc && (weight_addr_q == LAST_W);
  assign col_last     = (col_cnt_q == LAST_COL);
  assign frame_end    = p_acc && col_last && (row_cnt_q == LAST_ROW);

  assign state        = state_q;
  assign weight_addr  = weight_addr_q;
  assign col_cnt      = col_cnt_q;
  assign row_cnt      = row_cnt_q;
  assign window_valid = window_valid_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= S_IDLE;
      weight_addr_q       <= '0;
      col_cnt_q           <= '0;
      row_cnt_q           <= '0;
      window_valid_q      <= 1'b0;
      done_q              <= 1'b0;
      frame_end_pending_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      weight_addr_q       <= weight_addr_d;
      col_cnt_q           <= col_cnt_d;
      row_cnt_q           <= row_cnt_d;
      window_valid_q      <= window_valid_d;
      done_q              <= done_d;
      frame_end_pending_q <= frame_end_pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (last_w) state_d = frame_end_pending_q ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        // When the frame ends, that takes priority over a reload request in the same cycle.
        if (frame_end)       state_d = S_IDLE;
        else if (reload_req) state_d = S_SHIFT_LOAD;
      end
      S_SHIFT_LOAD: begin
        if (frame_end && last_w) state_d = S_IDLE;
        else if (frame_end)      state_d = S_LOAD_W;
        else if (last_w)         state_d = S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    weight_addr_d       = weight_addr_q;
    col_cnt_d           = col_cnt_q;
    row_cnt_d           = row_cnt_q;
    window_valid_d      = 1'b0;
    done_d              = 1'b0;
    frame_end_pending_d = frame_end_pending_q;
    if (state_q == S_IDLE) begin
      weight_addr_d       = '0;
      col_cnt_d           = '0;
      row_cnt_d           = '0;
      frame_end_pending_d = 1'b0;
    end else begin
      if (w_acc) weight_addr_d = last_w ? 4'd0 : weight_addr_q + 4'd1;
      if (p_acc) begin
        window_valid_d = (col_cnt_q >= WIN_COL);
        if (col_last) begin
          col_cnt_d = '0;
          // When the last row wraps, the counters clear for the next frame.
          row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end
      unique case (state_q)
        S_LOAD_W: begin
          if (last_w && frame_end_pending_q) begin
            done_d              = 1'b1;
            frame_end_pending_d = 1'b0;
          end
        end
        S_SHIFT: begin
          if (frame_end) done_d = 1'b1;
        end
        S_SHIFT_LOAD: begin
          if (frame_end && last_w) done_d = 1'b1;
          else if (frame_end)      frame_end_pending_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
